// File: rtl/sample_tile_reader.sv
// Raster-order reader for the sampled-tile buffer: issues buffer reads under a
// credit limit and streams pixels with sof/eol/eof tags through a 2-entry skid FIFO.
module sample_tile_reader #(
    parameter int TILE_W = 32,
    parameter int TILE_H = 32,
    parameter int DATA_W = 1,
    localparam int AW_C = $clog2(TILE_W),
    localparam int AW_R = $clog2(TILE_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_req,
    output logic [AW_R-1:0]   d_srow_cont,
    output logic [AW_C-1:0]   d_scol_cont,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] opixel,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // FIFO entry layout: {sof, eol, eof, pixel}
    localparam int EW = DATA_W + 3;

    state_t            state_q;
    logic [AW_R-1:0]   row_q;
    logic [AW_C-1:0]   col_q;
    logic              busy_q;
    logic              done_q;

    logic              inflight_q;
    logic [2:0]        tag_q;

    logic [1:0][EW-1:0] mem_q, mem_d;
    logic [1:0]         count_q, count_d;

    logic              pop;
    logic              push;
    logic [2:0]        credit_used;
    logic              last_col;
    logic              last_row;
    logic              issue_sof;
    logic              issue_eol;
    logic              issue_eof;
    logic [EW-1:0]     head;
    logic [EW-1:0]     wentry;
    logic              drain_done;

    assign last_col  = (col_q == AW_C'(TILE_W - 1));
    assign last_row  = (row_q == AW_R'(TILE_H - 1));
    assign issue_sof = (row_q == '0) && (col_q == '0);
    assign issue_eol = last_col;
    assign issue_eof = last_row && last_col;

    assign o_valid = (count_q != 2'd0);
    assign pop     = o_valid & o_ready;
    assign push    = inflight_q;

    // Credit: occupancy plus the read in flight, less this cycle's pop, must stay below 2.
    assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
    assign rd_req      = (state_q == READ) && (credit_used < (3'd2 + {2'b00, pop}));

    assign head   = mem_q[0];
    assign wentry = {tag_q, rd_data};

    // The eof beat is always the last one, so popping it with nothing behind it ends the tile.
    assign drain_done = pop && head[DATA_W] && (count_q == 2'd1) && !inflight_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    row_q <= '0;
                    col_q <= '0;
                    if (start) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_req) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                row_q <= row_q + AW_R'(1);
                            end
                        end else begin
                            col_q <= col_q + AW_C'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= rd_req;
            if (rd_req) begin
                tag_q <= {issue_sof, issue_eol, issue_eof};
            end
        end
    end

    // Entry 0 is always the head; a simultaneous push/pop shifts and refills in one step.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                mem_d[count_q[0]] = wentry;
                count_d           = count_q + 2'd1;
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    mem_d[0] = wentry;
                end else begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = wentry;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign opixel      = o_valid ? head[DATA_W-1:0] : '0;
    assign o_sof       = o_valid & head[EW-1];
    assign o_eol       = o_valid & head[EW-2];
    assign o_eof       = o_valid & head[DATA_W];
    assign busy        = busy_q;
    assign done        = done_q;
    assign d_srow_cont = row_q;
    assign d_scol_cont = col_q;

endmodule

// File: tb/tb_sample_tile_reader.sv
// Directed bench for sample_tile_reader: default 32x32 instance plus a 4x2 instance
// for the small-tile address/tag sequence.
module tb_sample_tile_reader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, o_ready;
    logic       rd_req, o_valid, o_sof, o_eol, o_eof, busy, done;
    logic [4:0] d_srow_cont, d_scol_cont;
    logic [0:0] rd_data, opixel;

    logic       start_s, o_ready_s;
    logic       rd_req_s, o_valid_s, sof_s, eol_s, eof_s, busy_s, done_s;
    logic [0:0] row_s;
    logic [1:0] col_s;
    logic [0:0] rd_data_s, opixel_s;

    int vec = 0;
    int err = 0;

    sample_tile_reader dut (
        .clk(clk), .reset(reset), .start(start), .rd_req(rd_req),
        .d_srow_cont(d_srow_cont), .d_scol_cont(d_scol_cont), .rd_data(rd_data),
        .opixel(opixel), .o_valid(o_valid), .o_ready(o_ready), .o_sof(o_sof),
        .o_eol(o_eol), .o_eof(o_eof), .busy(busy), .done(done)
    );

    sample_tile_reader #(.TILE_W(4), .TILE_H(2), .DATA_W(1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .rd_req(rd_req_s),
        .d_srow_cont(row_s), .d_scol_cont(col_s), .rd_data(rd_data_s),
        .opixel(opixel_s), .o_valid(o_valid_s), .o_ready(o_ready_s), .o_sof(sof_s),
        .o_eol(eol_s), .o_eof(eof_s), .busy(busy_s), .done(done_s)
    );

    // Buffer models: checkerboard pixel one cycle after the read; junk otherwise.
    always @(posedge clk) rd_data <= rd_req ? (d_srow_cont[0] ^ d_scol_cont[0]) : 1'($urandom);
    always @(posedge clk) rd_data_s <= row_s[0] ^ col_s[0];

    function automatic logic [3:0] exp_beat(input int b);
        int r, c;
        logic [3:0] e;
        r = b / 32;
        c = b % 32;
        e[3] = ((r ^ c) & 1) != 0;
        e[2] = (b == 0);
        e[1] = (c == 31);
        e[0] = (b == 1023);
        return e;
    endfunction

    task automatic test_reset();
        logic [17:0] obs;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b1;
            start = 1'($urandom);
            o_ready = 1'($urandom);
            start_s = 1'($urandom);
            #1;
            if (i == 1) begin
                obs = {rd_req, o_valid, o_sof, o_eol, o_eof, busy, done, opixel, d_srow_cont, d_scol_cont};
                vec++;
                if (obs !== '0) begin
                    err++;
                    $display("FAIL reset_outputs got=%h want=0", obs);
                end
                vec++;
                if ({rd_req_s, o_valid_s, busy_s, done_s} !== 4'b0) begin
                    err++;
                    $display("FAIL reset_outputs_small got=%b want=0000", {rd_req_s, o_valid_s, busy_s, done_s});
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            start_s = 1'b0;
            o_ready = 1'b0;
            #1;
            vec++;
            if ({busy, rd_req, done, o_valid} !== 4'b0) begin
                err++;
                $display("FAIL reset_start_ignored cyc=%0d got=%b want=0000", i, {busy, rd_req, done, o_valid});
            end
        end
    endtask

    task automatic test_full_tile(input string tag);
        logic exp_v;
        @(negedge clk);
        start = 1'b1;
        o_ready = 1'b1;
        #1;
        for (int c = 1; c <= 1030; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            exp_v = (c >= 3) && (c <= 1026);
            vec++;
            if (o_valid !== exp_v) begin
                err++;
                $display("FAIL %s_valid c=%0d got=%b want=%b", tag, c, o_valid, exp_v);
            end
            if (exp_v) begin
                vec++;
                if ({opixel, o_sof, o_eol, o_eof} !== exp_beat(c - 3)) begin
                    err++;
                    $display("FAIL %s_beat b=%0d got=%b want=%b", tag, c - 3, {opixel, o_sof, o_eol, o_eof}, exp_beat(c - 3));
                end
            end
            vec++;
            if (done !== (c == 1027)) begin
                err++;
                $display("FAIL %s_done c=%0d got=%b want=%b", tag, c, done, c == 1027);
            end
            vec++;
            if (busy !== (c <= 1027)) begin
                err++;
                $display("FAIL %s_busy c=%0d got=%b want=%b", tag, c, busy, c <= 1027);
            end
            vec++;
            if (rd_req !== (c <= 1024)) begin
                err++;
                $display("FAIL %s_rd_req c=%0d got=%b want=%b", tag, c, rd_req, c <= 1024);
            end
            if (c <= 1024) begin
                vec++;
                if ({d_srow_cont, d_scol_cont} !== 10'(c - 1)) begin
                    err++;
                    $display("FAIL %s_addr c=%0d got=%0d want=%0d", tag, c, {d_srow_cont, d_scol_cont}, c - 1);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int b = 0, occ = 0, infl = 0, dn = 0, cyc = 0, post = 0;
        logic stall_prev = 1'b0;
        logic [3:0] prev = '0;
        @(negedge clk);
        start = 1'b1;
        o_ready = 1'($urandom);
        #1;
        while (cyc < 6000 && post < 3) begin
            if (cyc > 0) begin
                @(negedge clk);
                start = 1'b0;
                o_ready = 1'($urandom);
                #1;
            end
            cyc++;
            vec++;
            if (o_valid !== (occ != 0)) begin
                err++;
                $display("FAIL bp_valid cyc=%0d got=%b want=%b", cyc, o_valid, occ != 0);
            end
            vec++;
            if (occ > 2) begin
                err++;
                $display("FAIL bp_occupancy cyc=%0d got=%0d want<=2", cyc, occ);
            end
            if (!o_ready && occ == 2) begin
                vec++;
                if (rd_req !== 1'b0) begin
                    err++;
                    $display("FAIL bp_credit cyc=%0d rd_req got=%b want=0", cyc, rd_req);
                end
            end
            if (stall_prev) begin
                vec++;
                if ({o_valid, opixel, o_sof, o_eol, o_eof} !== {1'b1, prev}) begin
                    err++;
                    $display("FAIL bp_stable cyc=%0d got=%b want=%b", cyc, {o_valid, opixel, o_sof, o_eol, o_eof}, {1'b1, prev});
                end
            end
            if (o_valid && o_ready) begin
                vec++;
                if ({opixel, o_sof, o_eol, o_eof} !== exp_beat(b)) begin
                    err++;
                    $display("FAIL bp_beat b=%0d got=%b want=%b", b, {opixel, o_sof, o_eol, o_eof}, exp_beat(b));
                end
                b++;
            end
            if (done) begin
                dn++;
                vec++;
                if (b !== 1024) begin
                    err++;
                    $display("FAIL bp_done_early got=%0d beats want=1024", b);
                end
            end
            if (dn > 0) post++;
            stall_prev = o_valid && !o_ready;
            prev = {opixel, o_sof, o_eol, o_eof};
            occ = occ - ((o_valid && o_ready) ? 1 : 0) + infl;
            infl = rd_req ? 1 : 0;
        end
        vec++;
        if (post < 3) begin
            err++;
            $display("FAIL bp_timeout got=%0d cycles want=done", cyc);
        end
        vec++;
        if (b !== 1024) begin
            err++;
            $display("FAIL bp_beat_count got=%0d want=1024", b);
        end
        vec++;
        if (dn !== 1) begin
            err++;
            $display("FAIL bp_done_count got=%0d want=1", dn);
        end
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL bp_busy_after got=%b want=0", busy);
        end
    endtask

    task automatic test_small_tile();
        int issued = 0, b = 0, dn = 0;
        logic [3:0] e;
        @(negedge clk);
        start_s = 1'b1;
        o_ready_s = 1'b1;
        #1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            #1;
            if (rd_req_s) begin
                vec++;
                if ({row_s, col_s} !== 3'(issued)) begin
                    err++;
                    $display("FAIL small_addr n=%0d got=%0d want=%0d", issued, {row_s, col_s}, issued);
                end
                issued++;
            end
            if (o_valid_s) begin
                e[3] = (((b / 4) ^ (b % 4)) & 1) != 0;
                e[2] = (b == 0);
                e[1] = (b == 3) || (b == 7);
                e[0] = (b == 7);
                vec++;
                if ({opixel_s, sof_s, eol_s, eof_s} !== e) begin
                    err++;
                    $display("FAIL small_beat b=%0d got=%b want=%b", b, {opixel_s, sof_s, eol_s, eof_s}, e);
                end
                b++;
            end
            if (done_s) dn++;
        end
        vec++;
        if (issued !== 8) begin
            err++;
            $display("FAIL small_reads got=%0d want=8", issued);
        end
        vec++;
        if (b !== 8) begin
            err++;
            $display("FAIL small_beats got=%0d want=8", b);
        end
        vec++;
        if (dn !== 1) begin
            err++;
            $display("FAIL small_done got=%0d want=1", dn);
        end
    endtask

    task automatic test_start_while_busy();
        int dn = 0, dn2 = 0, b = 0, k = 0;
        @(negedge clk);
        start = 1'b1;
        o_ready = 1'b1;
        #1;
        for (int c = 1; c <= 1029; c++) begin
            @(negedge clk);
            start = (c == 13) || (c == 1027) || (c == 1028);
            #1;
            if (done) dn++;
            if (c >= 3 && c <= 1026) begin
                vec++;
                if ({o_valid, opixel, o_sof, o_eol, o_eof} !== {1'b1, exp_beat(c - 3)}) begin
                    err++;
                    $display("FAIL swb_beat b=%0d got=%b want=%b", c - 3, {o_valid, opixel, o_sof, o_eol, o_eof}, {1'b1, exp_beat(c - 3)});
                end
            end
            if (c == 14) begin
                vec++;
                if ({busy, rd_req, d_srow_cont, d_scol_cont} !== {2'b11, 10'd13}) begin
                    err++;
                    $display("FAIL swb_no_restart got=%h want=%h", {busy, rd_req, d_srow_cont, d_scol_cont}, {2'b11, 10'd13});
                end
            end
            if (c == 1027) begin
                vec++;
                if (done !== 1'b1) begin
                    err++;
                    $display("FAIL swb_done got=%b want=1", done);
                end
            end
            if (c == 1028) begin
                vec++;
                if ({busy, rd_req, done} !== 3'b000) begin
                    err++;
                    $display("FAIL swb_idle got=%b want=000", {busy, rd_req, done});
                end
            end
            if (c == 1029) begin
                vec++;
                if ({busy, rd_req, d_srow_cont, d_scol_cont} !== {2'b11, 10'd0}) begin
                    err++;
                    $display("FAIL swb_restart got=%h want=%h", {busy, rd_req, d_srow_cont, d_scol_cont}, {2'b11, 10'd0});
                end
            end
        end
        vec++;
        if (dn !== 1) begin
            err++;
            $display("FAIL swb_done_count got=%0d want=1", dn);
        end
        while (dn2 == 0 && k < 1100) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            k++;
            if (o_valid) begin
                vec++;
                if ({opixel, o_sof, o_eol, o_eof} !== exp_beat(b)) begin
                    err++;
                    $display("FAIL swb_fresh_beat b=%0d got=%b want=%b", b, {opixel, o_sof, o_eol, o_eof}, exp_beat(b));
                end
                b++;
            end
            if (done) dn2++;
        end
        vec++;
        if (b !== 1024) begin
            err++;
            $display("FAIL swb_fresh_beats got=%0d want=1024", b);
        end
        vec++;
        if (dn2 !== 1) begin
            err++;
            $display("FAIL swb_fresh_done got=%0d want=1", dn2);
        end
    endtask

    task automatic test_reset_mid_tile();
        logic [17:0] obs;
        @(negedge clk);
        start = 1'b1;
        o_ready = 1'b1;
        #1;
        for (int c = 1; c <= 103; c++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (c == 103);
            #1;
            if (c == 103) begin
                vec++;
                if ({rd_req, o_valid, opixel, o_sof, o_eol, o_eof} !== {2'b11, exp_beat(100)}) begin
                    err++;
                    $display("FAIL rmt_pre got=%b want=%b", {rd_req, o_valid, opixel, o_sof, o_eol, o_eof}, {2'b11, exp_beat(100)});
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        obs = {rd_req, o_valid, o_sof, o_eol, o_eof, busy, done, opixel, d_srow_cont, d_scol_cont};
        vec++;
        if (obs !== '0) begin
            err++;
            $display("FAIL rmt_outputs got=%h want=0", obs);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            vec++;
            if ({o_valid, busy, rd_req} !== 3'b000) begin
                err++;
                $display("FAIL rmt_stale cyc=%0d got=%b want=000", i, {o_valid, busy, rd_req});
            end
        end
        test_full_tile("rmt_after");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        o_ready = 1'b0;
        start_s = 1'b0;
        o_ready_s = 1'b1;
        test_reset();
        test_full_tile("full");
        test_back_pressure();
        test_small_tile();
        test_start_while_busy();
        test_reset_mid_tile();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/sample_tile_reader.md
# sample_tile_reader

Read-side counterpart of the CCD sample clip path. After the clip stage has filled its sampled-tile buffer, this block walks the buffer in raster order (row-major), issuing `rd_req` with `d_srow_cont`/`d_scol_cont` addresses. It streams the returned pixels to a downstream consumer over a valid/ready handshake, with start-of-frame, end-of-line and end-of-frame tags. It sits between the sample buffer and the display/processing stage, and absorbs downstream back-pressure with a 2-entry skid FIFO.

## Interface
- `TILE_W`, default 32: tile columns; `AW_C = $clog2(TILE_W)`.
- `TILE_H`, default 32: tile rows; `AW_R = $clog2(TILE_H)`.
- `DATA_W`, default 1: pixel width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle pulse meaning the tile buffer is full and readout should begin.
- `rd_req` out 1: buffer read strobe.
- `d_srow_cont` out AW_R: read row address.
- `d_scol_cont` out AW_C: read column address.
- `rd_data` in DATA_W: buffer data, valid exactly 1 cycle after `rd_req`.
- `opixel` out DATA_W: output pixel.
- `o_valid` out 1: `opixel` and tags are valid.
- `o_ready` in 1: consumer accepts the beat.
- `o_sof` out 1: first pixel of the tile.
- `o_eol` out 1: last pixel of a row.
- `o_eof` out 1: last pixel of the tile.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final beat is accepted.

## Operation
- States:
  - IDLE:
    - `start` → READ.
    - Row and column counters load 0.
  - READ:
    - Issue reads subject to the credit rule.
    - After each issued read, the column increments. At `TILE_W-1` the column wraps to 0 and the row increments.
    - Issuing address (`TILE_H-1`, `TILE_W-1`) → DRAIN.
  - DRAIN:
    - Stay until FIFO count = 0, no read is in flight, and the eof beat has been accepted.
    - Then → DONE.
  - DONE: assert `done` for 1 cycle → IDLE.
- `start` is ignored in every state except IDLE.
- Credit rule: `rd_req` may be asserted only when `count + inflight - pop < 2`.
  - `count` is FIFO occupancy (0..2).
  - `inflight` is 1 if `rd_req` was asserted in the previous cycle, else 0.
  - `pop = o_valid & o_ready`.
  - This rule guarantees the FIFO never overflows and sustains 1 pixel/cycle while `o_ready` is held high.
- Tags are computed at issue time and carried through the pipeline and FIFO alongside the data:
  - sof: (0,0).
  - eol: col = `TILE_W-1`.
  - eof: (`TILE_H-1`, `TILE_W-1`).
- FIFO handling:
  - Returning `rd_data` is always written into the FIFO (space is guaranteed by the credit rule).
  - A push and a pop in the same cycle leave `count` unchanged.
  - The FIFO head drives `opixel` and the tags; `o_valid = (count != 0)`.
- Output stability: while `o_valid & !o_ready`, `opixel` and all tags hold stable.
- Address stability: `d_srow_cont`/`d_scol_cont` are valid in any cycle `rd_req` is high. They hold their value while `rd_req` is low.
- Reset (any state, including mid-tile):
  - Next state is IDLE and the FIFO is cleared.
  - `inflight` is cleared, so data returning from a read issued before reset is discarded.

## Timing
- Reset values: `rd_req`, `o_valid`, `o_sof`, `o_eol`, `o_eof`, `busy`, `done` = 0; `d_srow_cont`, `d_scol_cont`, `opixel` = 0.
- `start` sampled at edge S:
  - `busy` = 1 from cycle S+1.
  - First `rd_req` in cycle S+1, address (0,0).
- Read latency: `rd_req` in cycle k → `rd_data` in k+1 → FIFO write at end of k+1 → `o_valid` with that pixel from cycle k+2.
- Full tile with `o_ready` held at 1:
  - One beat per cycle, cycles S+3 .. S+2+TILE_W·TILE_H.
  - `done` is asserted the cycle after the eof handshake; `busy` falls in the same cycle `done` falls.
- Flow control: no combinational path from `o_ready` to `o_valid`; `rd_req` may depend combinationally on `o_ready` only through `pop`.

## Test plan
- Reset:
  - Stimulus: assert `reset` for 2 cycles with random inputs.
  - Required response: every output is 0; `start` during reset is ignored.
- Full tile, defaults:
  - Stimulus: buffer model returns `srow[0]^scol[0]`, `o_ready`=1, `start` at S.
  - Required response:
    - Exactly 1024 beats in cycles S+3..S+1026, forming a checkerboard.
    - `o_sof` on beat 0 only; `o_eol` on beats 31, 63, …, 1023; `o_eof` on beat 1023 only.
    - `done` high only in cycle S+1027.
- Back-pressure:
  - Stimulus: random `o_ready` (50%).
  - Required response:
    - Output sequence is identical to the ready=1 run, with no drops or duplicates.
    - `opixel`/tags are stable whenever `o_valid & !o_ready`.
    - FIFO occupancy never exceeds 2.
    - `rd_req` is 0 while `o_ready`=0 and FIFO count = 2.
- Small tile:
  - Stimulus: `TILE_W`=4, `TILE_H`=2.
  - Required response:
    - Addresses are issued in order (0,0)…(0,3),(1,0)…(1,3).
    - `o_eol` on beats 3 and 7; `o_eof` on beat 7.
    - `done` fires once.
- Start while busy:
  - Stimulus: pulse `start` at beat 10 and again during DONE.
  - Required response: no restart occurs and still exactly one `done`; a `start` one cycle after the `done` cycle begins a fresh tile at (0,0).
- Reset mid-tile:
  - Stimulus: assert `reset` at beat 100 while a read is in flight.
  - Required response:
    - The next cycle shows all outputs 0.
    - The stale `rd_data` is not emitted.
    - A subsequent `start` produces 1024 beats beginning with sof.
